reset_sequencer: RTL and testbench

Releases the board's reset domains one at a time, in a fixed order, after the PLL has locked. It sits downstream of the per-domain reset synchronizers and drives the active-high stage resets for the SRAM, SPI bridge and UART/processor domains. The block also supports a software-requested warm reset and restarts the sequence if the PLL loses lock.

---
 rtl/reset_sequencer.sv | 160 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Purpose: releases the stage resets one at a time, in order, after the PLL has locked; handles warm reset and lock loss.
// Latency: RELEASE starts LOCK_FILTER edges after lock is seen; stage k is released (k+1)*STAGE_DELAY edges after that.
// Backpressure: none; all outputs come straight from flops, and inputs are sampled on every edge.
module reset_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int STAGE_DELAY   = 16,
    parameter int LOCK_FILTER   = 8,
    parameter int SW_RESET_HOLD = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pll_lock,
    input  logic                  soft_reset_req,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  sequence_done,
    output logic                  lock_lost,
    output logic [1:0]            state
);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_RELEASE   = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_SW_RESET  = 2'd3;

    localparam int LF_W   = $clog2(LOCK_FILTER) + 1;
    localparam int DLY_W  = $clog2(STAGE_DELAY) + 1;
    localparam int HOLD_W = $clog2(SW_RESET_HOLD) + 1;
    localparam int IDX_W  = $clog2(NUM_STAGES) + 1;

    // Terminal counts: each counter clears on reaching these instead of wrapping.
    localparam logic [LF_W-1:0]   LF_LAST   = LF_W'(LOCK_FILTER - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SW_RESET_HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    logic [1:0]            state_q, state_d;
    logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
    logic                  done_q, done_d;
    logic                  lock_lost_q, lock_lost_d;
    logic [LF_W-1:0]       lf_cnt_q, lf_cnt_d;
    logic [DLY_W-1:0]      dly_cnt_q, dly_cnt_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    // Next-state logic: lock loss beats soft reset, which beats the normal release step.
    always_comb begin
        state_d       = state_q;
        stage_reset_d = stage_reset_q;
        done_d        = done_q;
        lock_lost_d   = 1'b0;
        lf_cnt_d      = lf_cnt_q;
        dly_cnt_d     = dly_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        idx_d         = idx_q;

        if (state_q != ST_WAIT_LOCK && !pll_lock) begin
            // Lost lock: slam every stage back into reset and refilter the lock.
            state_d       = ST_WAIT_LOCK;
            stage_reset_d = '1;
            done_d        = 1'b0;
            lock_lost_d   = 1'b1;
            lf_cnt_d      = '0;
            dly_cnt_d     = '0;
            hold_cnt_d    = '0;
            idx_d         = '0;
        end else if ((state_q == ST_RELEASE || state_q == ST_RUN) && soft_reset_req) begin
            state_d       = ST_SW_RESET;
            stage_reset_d = '1;
            done_d        = 1'b0;
            lf_cnt_d      = '0;
            dly_cnt_d     = '0;
            hold_cnt_d    = '0;
            idx_d         = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (!pll_lock) begin
                        lf_cnt_d = '0;
                    end else if (lf_cnt_q == LF_LAST) begin
                        state_d   = ST_RELEASE;
                        lf_cnt_d  = '0;
                        dly_cnt_d = '0;
                        idx_d     = '0;
                    end else begin
                        lf_cnt_d = lf_cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (dly_cnt_q == DLY_LAST) begin
                        dly_cnt_d = '0;
                        // Shifting a zero in from bit 0 keeps releases strictly in order.
                        stage_reset_d = stage_reset_q << 1;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        dly_cnt_d = dly_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    stage_reset_d = '0;
                    done_d        = 1'b1;
                end
                ST_SW_RESET: begin
                    // The PLL is still locked here, so go straight back to releasing.
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_RELEASE;
                        hold_cnt_d = '0;
                        dly_cnt_d  = '0;
                        idx_d      = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d       = ST_WAIT_LOCK;
                    stage_reset_d = '1;
                    done_d        = 1'b0;
                    lf_cnt_d      = '0;
                    dly_cnt_d     = '0;
                    hold_cnt_d    = '0;
                    idx_d         = '0;
                end
            endcase
        end
    end

    // State and output registers; reset forces every stage into reset without waiting for a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_WAIT_LOCK;
            stage_reset_q <= '1;
            done_q        <= 1'b0;
            lock_lost_q   <= 1'b0;
            lf_cnt_q      <= '0;
            dly_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            idx_q         <= '0;
        end else begin
            state_q       <= state_d;
            stage_reset_q <= stage_reset_d;
            done_q        <= done_d;
            lock_lost_q   <= lock_lost_d;
            lf_cnt_q      <= lf_cnt_d;
            dly_cnt_q     <= dly_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            idx_q         <= idx_d;
        end
    end

    assign stage_reset   = stage_reset_q;
    assign sequence_done = done_q;
    assign lock_lost     = lock_lost_q;
    assign state         = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
// Output vector compared each edge: {state, sequence_done, lock_lost, stage_reset}.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       pll_lock;
    logic       soft_reset_req;
    logic [2:0] stage_reset;
    logic       sequence_done;
    logic       lock_lost;
    logic [1:0] state;

    logic [6:0] obs;
    int         n_cmp;
    int         n_err;

    localparam logic [6:0] WAIT_V = 7'b00_0_0_111;
    localparam logic [6:0] LOST_V = 7'b00_0_1_111;
    localparam logic [6:0] SW_V   = 7'b11_0_0_111;

    reset_sequencer #(
        .NUM_STAGES   (3),
        .STAGE_DELAY  (16),
        .LOCK_FILTER  (8),
        .SW_RESET_HOLD(32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pll_lock      (pll_lock),
        .soft_reset_req(soft_reset_req),
        .stage_reset   (stage_reset),
        .sequence_done (sequence_done),
        .lock_lost     (lock_lost),
        .state         (state)
    );

    assign obs = {state, sequence_done, lock_lost, stage_reset};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs r edges after entering RELEASE (r = 0 is the entry edge).
    function automatic logic [6:0] rel_exp(input int r);
        logic [2:0] sr;
        logic [1:0] st;
        logic       dn;
        if (r < 16)      sr = 3'b111;
        else if (r < 32) sr = 3'b110;
        else if (r < 48) sr = 3'b100;
        else             sr = 3'b000;
        st = (r < 48) ? 2'd1 : 2'd2;
        dn = (r >= 48);
        return {st, dn, 1'b0, sr};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        pll_lock       = 1'b0;
        soft_reset_req = 1'b0;
        #2;
        n_cmp++;
        if (obs !== WAIT_V) begin
            n_err++;
            $display("FAIL reset_initial: got %b expected %b", obs, WAIT_V);
        end
        pll_lock = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_cmp++;
            if (obs !== WAIT_V) begin
                n_err++;
                $display("FAIL reset_held edge %0d: got %b expected %b", i, obs, WAIT_V);
            end
        end
        pll_lock = 1'b0;
    endtask

    // Lock filter then full release; expects 'edges' edges from the first high lock sample.
    task automatic run_sequence(input string name, input int edges);
        logic [6:0] exp_v;
        for (int e = 1; e <= edges; e++) begin
            step();
            exp_v = (e < 8) ? WAIT_V : rel_exp(e - 8);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL %s edge %0d: got %b expected %b", name, e, obs, exp_v);
            end
        end
    endtask

    task automatic test_normal_start();
        reset    = 1'b0;
        pll_lock = 1'b1;
        run_sequence("normal_start", 60);
    endtask

    task automatic test_lock_loss_run();
        pll_lock = 1'b0;
        step();
        n_cmp++;
        if (obs !== LOST_V) begin
            n_err++;
            $display("FAIL lock_loss_run_pulse: got %b expected %b", obs, LOST_V);
        end
        pll_lock = 1'b1;
        run_sequence("lock_loss_resequence", 60);
    endtask

    task automatic test_soft_reset_run();
        logic [6:0] exp_v;
        soft_reset_req = 1'b1;
        step();
        n_cmp++;
        if (obs !== SW_V) begin
            n_err++;
            $display("FAIL soft_reset_entry: got %b expected %b", obs, SW_V);
        end
        // Keep requesting for a few more edges; the hold must not restart.
        for (int k = 1; k <= 84; k++) begin
            if (k == 5) soft_reset_req = 1'b0;
            step();
            exp_v = (k < 32) ? SW_V : rel_exp(k - 32);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL soft_reset edge %0d: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_simultaneous_run();
        pll_lock       = 1'b0;
        soft_reset_req = 1'b1;
        step();
        n_cmp++;
        if (obs !== LOST_V) begin
            n_err++;
            $display("FAIL simultaneous_priority: got %b expected %b", obs, LOST_V);
        end
        // Soft reset stays requested while the lock filters; it must be ignored.
        pll_lock = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_cmp++;
            if (obs !== ((e < 8) ? WAIT_V : rel_exp(0))) begin
                n_err++;
                $display("FAIL soft_ignored_wait edge %0d: got %b expected %b", e, obs,
                         (e < 8) ? WAIT_V : rel_exp(0));
            end
        end
        soft_reset_req = 1'b0;
    endtask

    task automatic test_async_reset_release();
        for (int r = 1; r <= 16; r++) step();
        n_cmp++;
        if (obs !== rel_exp(16)) begin
            n_err++;
            $display("FAIL async_pre_state: got %b expected %b", obs, rel_exp(16));
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== WAIT_V) begin
            n_err++;
            $display("FAIL async_reset_immediate: got %b expected %b", obs, WAIT_V);
        end
        step();
        step();
        pll_lock = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic test_lock_glitch_wait();
        logic [6:0] exp_v;
        for (int e = 1; e <= 16; e++) begin
            pll_lock = (e != 6);
            step();
            exp_v = (e < 14) ? WAIT_V : rel_exp(e - 14);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL lock_glitch edge %0d: got %b expected %b", e, obs, exp_v);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_normal_start();
        test_lock_loss_run();
        test_soft_reset_run();
        test_simultaneous_run();
        test_async_reset_release();
        test_lock_glitch_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
